// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings and word packing.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_t;

    // Requests beyond the RAM depth are clamped so the load never laps the array.
    function automatic logic [5:0] clamp_count(input logic [5:0] req, input logic [5:0] depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream loader for the 32x32 instruction RAM; packs big-endian words and holds the CPU
// until the requested number of words has been written.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, CPU held, waiting for start
// ST_RECV  | collecting bytes of the current word (byte_ready=1)
// ST_WRITE | single write cycle of the assembled word
// ST_DONE  | program loaded, CPU released, waiting for a reload start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     word_count,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    byte_ready,
    output logic                    ram_ena,
    output logic                    ram_wena,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_indata,
    output logic                    cpu_hold,
    output logic                    done
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    ld_state_t                 r_state;
    ld_state_t                 w_state_nxt;
    logic [1:0]                r_byte_cnt;
    logic [ADDR_WIDTH:0]       r_word_cnt;
    logic [ADDR_WIDTH:0]       r_n;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_shift;

    logic                      w_start_ok;
    logic                      w_accept;
    logic                      w_last_byte;
    logic                      w_last_word;
    logic [ADDR_WIDTH:0]       w_n;
    logic [ADDR_WIDTH:0]       w_words_nxt;

    // start only counts when the loader is not mid-transfer
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept    = byte_valid && (r_state == ST_RECV);
    assign w_last_byte = (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign w_n         = clamp_count(word_count, DEPTH_W);
    assign w_words_nxt = r_word_cnt + (ADDR_WIDTH+1)'(1);
    assign w_last_word = (w_words_nxt == r_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = (w_n == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (w_accept && w_last_byte) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = w_last_word ? ST_DONE : ST_RECV;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        ram_ena    = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        case (r_state)
            ST_RECV:  byte_ready = 1'b1;
            ST_WRITE: ram_ena    = 1'b1;
            ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign ram_wena   = ram_ena;
    assign ram_addr   = r_addr;
    assign ram_indata = ram_ena ? r_shift : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_n        <= '0;
            r_addr     <= '0;
            r_shift    <= '0;
        end else begin
            if (w_start_ok) begin
                r_n        <= w_n;
                r_addr     <= '0;
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
            end
            if (w_accept) begin
                r_shift    <= {r_shift[DATA_WIDTH-9:0], byte_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (r_state == ST_WRITE) begin
                r_addr     <= r_addr + ADDR_WIDTH'(1);
                r_word_cnt <= w_words_nxt;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: captures RAM writes into a local array and checks them.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        ram_ena;
    logic        ram_wena;
    logic [4:0]  ram_addr;
    logic [31:0] ram_indata;
    logic        cpu_hold;
    logic        done;

    logic [31:0] mem [32];
    int          wr_cnt = 0;
    logic [4:0]  last_addr = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          base;

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .ram_ena    (ram_ena),
        .ram_wena   (ram_wena),
        .ram_addr   (ram_addr),
        .ram_indata (ram_indata),
        .cpu_hold   (cpu_hold),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (ram_ena) begin
            mem[ram_addr] = ram_indata;
            last_addr     = ram_addr;
            wr_cnt++;
            chk("wena_eq_ena", {31'd0, ram_wena}, 32'd1);
        end
    end

    task automatic pulse_start(input logic [5:0] n);
        start      = 1'b1;
        word_count = n;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(posedge clk);
        #1;
        byte_data  = b;
        byte_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("byte_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
    endtask

    function automatic logic [31:0] w4(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'hA5, 8'h5A, ~b};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_ram_ena",    {31'd0, ram_ena},    32'd0);
        chk("rst_ram_addr",   {27'd0, ram_addr},   32'd0);
        chk("rst_ram_indata", ram_indata,          32'd0);
        chk("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        chk("rst_done",       {31'd0, done},       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);

        // word_count=0: straight to DONE, no write
        pulse_start(6'd0);
        chk("n0_done",     {31'd0, done},     32'd1);
        chk("n0_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (2) @(posedge clk); #1;
        chk("n0_no_write", 32'(wr_cnt), 32'd0);

        // single word, back-to-back bytes
        pulse_start(6'd1);
        chk("t1_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t1_done_clr", {31'd0, done}, 32'd0);
        send_word(32'h8C010004, 0);
        chk("t1_wr_ena",  {31'd0, ram_ena}, 32'd1);
        chk("t1_wr_addr", {27'd0, ram_addr}, 32'd0);
        chk("t1_wr_data", ram_indata, 32'h8C010004);
        chk("t1_rdy_low", {31'd0, byte_ready}, 32'd0);
        @(posedge clk); #1;
        chk("t1_done",    {31'd0, done},     32'd1);
        chk("t1_hold0",   {31'd0, cpu_hold}, 32'd0);
        chk("t1_addr1",   {27'd0, ram_addr}, 32'd1);
        chk("t1_wrcnt",   32'(wr_cnt),       32'd1);

        // three words with valid toggling
        base = wr_cnt;
        pulse_start(6'd3);
        for (int i = 0; i < 3; i++) begin
            send_word({8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)}, 1);
            if (i == 1) begin
                @(posedge clk); #1;
                chk("t2_hold_mid", {31'd0, cpu_hold}, 32'd1);
            end
        end
        @(posedge clk); #1;
        chk("t2_wrcnt", 32'(wr_cnt - base), 32'd3);
        chk("t2_mem0",  mem[0], 32'h10203040);
        chk("t2_mem1",  mem[1], 32'h11213141);
        chk("t2_mem2",  mem[2], 32'h12223242);
        chk("t2_last",  {27'd0, last_addr}, 32'd2);
        chk("t2_hold0", {31'd0, cpu_hold}, 32'd0);

        // oversize count clamps to the RAM depth
        base = wr_cnt;
        pulse_start(6'd40);
        for (int i = 0; i < 32; i++) send_word(w4(i), 0);
        @(posedge clk); #1;
        chk("t4_wrcnt", 32'(wr_cnt - base), 32'd32);
        chk("t4_last",  {27'd0, last_addr}, 32'd31);
        chk("t4_addr0", {27'd0, ram_addr}, 32'd0);
        chk("t4_done",  {31'd0, done}, 32'd1);
        chk("t4_mem0",  mem[0],  w4(0));
        chk("t4_mem17", mem[17], w4(17));
        chk("t4_mem31", mem[31], w4(31));

        // reset in the middle of word 1
        base = wr_cnt;
        pulse_start(6'd2);
        send_word(32'hDEADBEEF, 0);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rdy",    {31'd0, byte_ready}, 32'd0);
        chk("t5_ena",    {31'd0, ram_ena},    32'd0);
        chk("t5_addr",   {27'd0, ram_addr},   32'd0);
        chk("t5_data",   ram_indata,          32'd0);
        chk("t5_hold",   {31'd0, cpu_hold},   32'd1);
        chk("t5_done",   {31'd0, done},       32'd0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        repeat (3) @(posedge clk); #1;
        chk("t5_idle_rdy", {31'd0, byte_ready}, 32'd0);
        chk("t5_idle_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t5_wrcnt", 32'(wr_cnt - base), 32'd1);
        chk("t5_mem0",  mem[0], 32'hDEADBEEF);
        byte_valid = 1'b0;

        // start during RECV ignored, then reload from DONE
        base = wr_cnt;
        pulse_start(6'd2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        pulse_start(6'd5);
        chk("t6_rdy_kept", {31'd0, byte_ready}, 32'd1);
        chk("t6_addr_kept", {27'd0, ram_addr}, 32'd0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        send_word(32'h01020304, 2);
        @(posedge clk); #1;
        chk("t6_wrcnt", 32'(wr_cnt - base), 32'd2);
        chk("t6_done",  {31'd0, done}, 32'd1);
        chk("t6_addr2", {27'd0, ram_addr}, 32'd2);
        pulse_start(6'd1);
        chk("t6_re_done", {31'd0, done}, 32'd0);
        chk("t6_re_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t6_re_addr", {27'd0, ram_addr}, 32'd0);
        send_word(32'h2402000A, 1);
        @(posedge clk); #1;
        chk("t6_rb0", mem[0], 32'h2402000A);
        chk("t6_rb1", mem[1], 32'h01020304);
        chk("t6_last", {27'd0, last_addr}, 32'd0);
        chk("t6_wrcnt2", 32'(wr_cnt - base), 32'd3);
        chk("t6_hold0", {31'd0, cpu_hold}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
